seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed driver for the 4-digit common-anode 7-segment display. Consumes
//  the four 4-bit digit codes selected by the display multiplexor (current/alarm/
//  keypad time). Scans one digit per slot, decodes it to active-low segments, drives
//  the colon, and optionally blinks the whole display while the alarm rings.
// PARAMETERS
//  SCAN_DIV     1000  clk cycles per digit slot; must be >= 2
//  BLINK_SLOTS  250   digit slots per blink half-period; used only with BLINK_EN
// PORTS
//  clk        in   1  system clock, single domain
//  reset_n    in   1  asynchronous active-low reset
//  segment_0  in   4  minutes units digit code
//  segment_1  in   4  minutes tens digit code
//  segment_2  in   4  hours units digit code
//  segment_3  in   4  hours tens digit code
//  lz_blank   in   1  1 = blank digit 3 when its code is 0
//  colon_on   in   1  1 = light the hh:mm colon
//  blink      in   1  1 = blink the whole display (alarm ringing)
//  anode_n    out  4  digit enables, active low; bit i selects segment_i
//  seg_n      out  7  {g,f,e,d,c,b,a}, active low
//  colon_n    out  1  colon LED, active low
// BEHAVIOUR
//  - Reset values: anode_n=4'hF, seg_n=7'h7F, colon_n=1; prescaler=0, digit idx=0,
//    blink counter=0, blink phase=visible. Reset takes effect immediately.
//  - Prescaler counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where count==SCAN_DIV-1.
//  - On tick:
//    - idx advances 0->1->2->3->0.
//    - The new digit's code is sampled from segment_<new idx> and seg_n is registered
//      from the decode.
//    - anode_n is forced to 4'hF for that one cycle (dead time, anti-ghosting).
//  - Cycle after tick: anode_n = ~(4'b0001 << idx). anode_n and seg_n then hold until
//    the next tick.
//  - Input changes mid-slot are not shown until the next slot.
//  - First digit lights at cycle SCAN_DIV+1 after reset release, with idx=1.
//  - Decode: codes 0-9 map to the standard glyphs. 0 -> 7'b1000000, 1 -> 7'b1111001,
//    8 -> 7'b0000000. Code 0xF -> dash 7'b0111111. Codes 0xA-0xE -> blank 7'h7F.
//  - Leading-zero blank: when idx==3, lz_blank==1 and segment_3==0, seg_n=7'h7F.
//    The anode still scans normally.
//  - colon_n = ~colon_on, registered on every clk (one-cycle latency). Not gated by the scan.
//  - Exactly one anode is low, except during dead-time cycles and blink-off phases.
// CONFIGURATION
//  - ALARM_BLINK_EN defined:
//    - A blink counter counts ticks 0..BLINK_SLOTS-1; the phase toggles on wrap.
//    - While blink==1 and phase==off, anode_n=4'hF and colon_n=1.
//    - When blink falls, the counter and phase clear in that cycle. The display is
//      visible from the next slot.
//  - ALARM_BLINK_EN undefined: the blink port exists but is ignored; no counter is
//    synthesised.
// STRUCTURE
//  - alarm_display_pkg: SEG_BLANK, SEG_DASH, 16-entry glyph constant table,
//    DIGIT_CODE_DASH (4'hF).
//  - One sub-module: seg7_decode (combinational 4-bit code -> 7-bit active-low pattern,
//    uses the package table).
//  - Top holds the prescaler, idx counter, output registers and the optional blink logic.
// TESTING (SCAN_DIV=4, BLINK_SLOTS=2)
//  1. Hold reset_n=0, then drive inputs -> anode_n=F, seg_n=7F, colon_n=1 throughout.
//     Release -> first tick at cycle 4 with anode_n=F; anode_n=4'b1101 at cycle 5.
//  2. segment_0..3 = 4,3,2,1 -> anode order 1101,1011,0111,1110 repeating. Each slot
//     lasts 3 lit cycles plus 1 dead-time cycle, with the matching glyphs.
//  3. segment_3=0: lz_blank=1 -> seg_n=7F in slot 3. lz_blank=0 -> seg_n=7'b1000000.
//     Codes 0xF and 0xB -> 7'b0111111 and 7'h7F.
//  4. Change segment_1 mid-slot 1 -> seg_n unchanged until slot 1 recurs.
//     colon_on toggle -> colon_n follows after 1 cycle.
//  5. ALARM_BLINK_EN with blink=1 -> anodes visible for 2 slots, dark for 2 slots,
//     colon dark in step. blink=0 -> normal scan resumes. Without the macro -> no blanking.
//  6. Assert reset_n mid-slot (anode lit) -> outputs go to reset values the same cycle.
//     Restart matches scenario 1.

Source files
------------

// File: rtl/alarm_display_pkg.sv
// Shared constants for the alarm-clock display path: segment patterns,
// the glyph table for 4-bit digit codes and the blink phase type.
package alarm_display_pkg;

    localparam logic [6:0] SEG_BLANK       = 7'h7F;
    localparam logic [6:0] SEG_DASH        = 7'h3F;
    localparam logic [3:0] DIGIT_CODE_DASH = 4'hF;

    // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        SEG_DASH,   // F
        SEG_BLANK,  // E
        SEG_BLANK,  // D
        SEG_BLANK,  // C
        SEG_BLANK,  // B
        SEG_BLANK,  // A
        7'b0010000, // 9
        7'b0000000, // 8
        7'b1111000, // 7
        7'b0000010, // 6
        7'b0010010, // 5
        7'b0011001, // 4
        7'b0110000, // 3
        7'b0100100, // 2
        7'b1111001, // 1
        7'b1000000  // 0
    };

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_OFF     = 1'b1
    } blink_phase_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit code to active-low 7-segment pattern.
module seg7_decode
    import alarm_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    assign seg_n = GLYPH_TABLE[code];

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-segment scanner with dead-time and colon drive.
// Define ALARM_BLINK_EN to build the whole-display blink used while the alarm rings.
module seven_seg_scanner
    import alarm_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLINK_SLOTS = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] segment_0,
    input  logic [3:0] segment_1,
    input  logic [3:0] segment_2,
    input  logic [3:0] segment_3,
    input  logic       lz_blank,
    input  logic       colon_on,
    input  logic       blink,
    output logic [3:0] anode_n,
    output logic [6:0] seg_n,
    output logic       colon_n
);

    localparam int unsigned      PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [3:0]    code_next;
    logic [6:0]    glyph;
    logic          blank_lz;
    logic          dead_q;
    logic          hide_slot;

    assign tick     = (pre_cnt == PRE_LAST);
    assign idx_next = idx + 2'd1;

    always_comb begin
        code_next = segment_0;
        case (idx_next)
            2'd0: code_next = segment_0;
            2'd1: code_next = segment_1;
            2'd2: code_next = segment_2;
            2'd3: code_next = segment_3;
            default: code_next = segment_0;
        endcase
    end

    assign blank_lz = (idx_next == 2'd3) && lz_blank && (segment_3 == 4'h0);

    seg7_decode u_decode (
        .code  (code_next),
        .seg_n (glyph)
    );

    // Tick loads the new digit with anodes dark; the anode is enabled one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            idx     <= '0;
            dead_q  <= 1'b0;
            anode_n <= '1;
            seg_n   <= SEG_BLANK;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                idx     <= idx_next;
                seg_n   <= blank_lz ? SEG_BLANK : glyph;
                anode_n <= '1;
                dead_q  <= 1'b1;
            end else if (dead_q) begin
                anode_n <= hide_slot ? 4'hF : ~(4'b0001 << idx);
                dead_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            colon_n <= 1'b1;
        end else begin
            colon_n <= ~colon_on | hide_slot;
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int unsigned   BW         = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_SLOTS - 1);

    logic [BW-1:0] blink_cnt;
    blink_phase_t  phase;

    // Darkness is latched per slot so a falling blink only shows at the next slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            phase     <= PH_VISIBLE;
            hide_slot <= 1'b0;
        end else begin
            if (tick) begin
                hide_slot <= blink && (phase == PH_OFF);
            end
            if (!blink) begin
                blink_cnt <= '0;
                phase     <= PH_VISIBLE;
            end else if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= (phase == PH_OFF) ? PH_VISIBLE : PH_OFF;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_blink;
    assign unused_blink = blink;
    assign hide_slot    = 1'b0;
`endif

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (SCAN_DIV=4, BLINK_SLOTS=2).
module tb_seven_seg_scanner;

    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned BLINK_SLOTS = 2;

`ifdef ALARM_BLINK_EN
    localparam bit BLINK_BUILT = 1'b1;
`else
    localparam bit BLINK_BUILT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] segment_0, segment_1, segment_2, segment_3;
    logic       lz_blank, colon_on, blink;
    logic [3:0] anode_n;
    logic [6:0] seg_n;
    logic       colon_n;

    int compared   = 0;
    int mismatched = 0;
    int exp_idx    = 0;

    typedef struct packed {
        logic [3:0] s0, s1, s2, s3;
        logic       lz;
        logic [6:0] e0, e1, e2, e3;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_SLOTS (BLINK_SLOTS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .segment_0 (segment_0),
        .segment_1 (segment_1),
        .segment_2 (segment_2),
        .segment_3 (segment_3),
        .lz_blank  (lz_blank),
        .colon_on  (colon_on),
        .blink     (blink),
        .anode_n   (anode_n),
        .seg_n     (seg_n),
        .colon_n   (colon_n)
    );

    function automatic logic [3:0] anode_of(input int i);
        case (i)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hF: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] cur_exp(input int i);
        case (i)
            0: return glyph(segment_0);
            1: return glyph(segment_1);
            2: return glyph(segment_2);
            default: return (lz_blank && segment_3 == 4'h0) ? 7'h7F : glyph(segment_3);
        endcase
    endfunction

    function automatic logic [6:0] pick(input vec_t v, input int i);
        case (i)
            0: return v.e0;
            1: return v.e1;
            2: return v.e2;
            default: return v.e3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v);
        segment_0 = v.s0;
        segment_1 = v.s1;
        segment_2 = v.s2;
        segment_3 = v.s3;
        lz_blank  = v.lz;
    endtask

    task automatic check_slot(input logic [6:0] exp_seg, input bit dark);
        exp_idx = (exp_idx + 1) % 4;
        step();
        chk("dead_anode", {3'b0, anode_n}, 7'h0F);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("anode", {3'b0, anode_n}, {3'b0, dark ? 4'hF : anode_of(exp_idx)});
            chk("seg", seg_n, exp_seg);
            chk("colon", {6'b0, colon_n}, {6'b0, dark | ~colon_on});
        end
    endtask

    task automatic startup();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("pre_tick_anode", {3'b0, anode_n}, 7'h0F);
            chk("pre_tick_seg", seg_n, 7'h7F);
        end
    endtask

    initial begin
        vecs[0] = '{s0:4'd4, s1:4'd3, s2:4'd2, s3:4'd1, lz:1'b0,
                    e0:7'h19, e1:7'h30, e2:7'h24, e3:7'h79};
        vecs[1] = '{s0:4'd8, s1:4'd5, s2:4'd6, s3:4'd0, lz:1'b1,
                    e0:7'h00, e1:7'h12, e2:7'h02, e3:7'h7F};
        vecs[2] = '{s0:4'd8, s1:4'd5, s2:4'd6, s3:4'd0, lz:1'b0,
                    e0:7'h00, e1:7'h12, e2:7'h02, e3:7'h40};
        vecs[3] = '{s0:4'd9, s1:4'hF, s2:4'hB, s3:4'd7, lz:1'b1,
                    e0:7'h10, e1:7'h3F, e2:7'h7F, e3:7'h78};
        vecs[4] = '{s0:4'd0, s1:4'hA, s2:4'hE, s3:4'd2, lz:1'b1,
                    e0:7'h40, e1:7'h7F, e2:7'h7F, e3:7'h24};

        apply(vecs[0]);
        colon_on = 1'b1;
        blink    = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);

        // Held in reset while inputs are live.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_anode", {3'b0, anode_n}, 7'h0F);
            chk("rst_seg", seg_n, 7'h7F);
            chk("rst_colon", {6'b0, colon_n}, 7'h01);
            colon_on = ~colon_on;
        end
        colon_on = 1'b1;
        reset_n  = 1'b1;
        exp_idx  = 0;
        startup();

        for (int v = 0; v < 5; v++) begin
            apply(vecs[v]);
            for (int s = 0; s < 4; s++) begin
                check_slot(pick(vecs[v], (exp_idx + 1) % 4), 1'b0);
            end
        end

        // Mid-slot input change and colon latency.
        apply(vecs[0]);
        exp_idx = (exp_idx + 1) % 4;
        step();
        chk("m_dead_anode", {3'b0, anode_n}, 7'h0F);
        step();
        chk("m_anode", {3'b0, anode_n}, {3'b0, anode_of(exp_idx)});
        chk("m_seg", seg_n, 7'h30);
        segment_1 = 4'd8;
        colon_on  = 1'b0;
        #1;
        chk("colon_hold", {6'b0, colon_n}, 7'h00);
        step();
        chk("m_seg_hold", seg_n, 7'h30);
        chk("colon_off", {6'b0, colon_n}, 7'h01);
        colon_on = 1'b1;
        step();
        chk("m_seg_hold2", seg_n, 7'h30);
        chk("colon_on", {6'b0, colon_n}, 7'h00);
        for (int s = 0; s < 4; s++) begin
            check_slot(cur_exp((exp_idx + 1) % 4), 1'b0);
        end

        // Blink: visible 2, dark 2 ...; falling blink clears the counter.
        blink = 1'b1;
        for (int s = 0; s < 7; s++) begin
            check_slot(cur_exp((exp_idx + 1) % 4), BLINK_BUILT && (s % 4 >= 2));
        end
        blink = 1'b0;
        for (int s = 0; s < 2; s++) begin
            check_slot(cur_exp((exp_idx + 1) % 4), 1'b0);
        end
        blink = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check_slot(cur_exp((exp_idx + 1) % 4), BLINK_BUILT && (s == 2));
        end
        blink = 1'b0;
        check_slot(cur_exp((exp_idx + 1) % 4), 1'b0);

        // Asynchronous reset while a digit is lit.
        exp_idx = (exp_idx + 1) % 4;
        step();
        step();
        chk("pre_rst_anode", {3'b0, anode_n}, {3'b0, anode_of(exp_idx)});
        reset_n = 1'b0;
        #1;
        chk("async_rst_anode", {3'b0, anode_n}, 7'h0F);
        chk("async_rst_seg", seg_n, 7'h7F);
        chk("async_rst_colon", {6'b0, colon_n}, 7'h01);
        step();
        step();
        chk("rst2_anode", {3'b0, anode_n}, 7'h0F);
        reset_n = 1'b1;
        exp_idx = 0;
        startup();
        for (int s = 0; s < 4; s++) begin
            check_slot(cur_exp((exp_idx + 1) % 4), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
